serial_alu: RTL

SERIAL_ALU -- requirements
Module: serial_alu

---
 rtl/serial_alu_pkg.sv | 21 ++
 rtl/serial_alu_slice.sv | 34 +++
 rtl/serial_alu.sv | 100 ++++++++++
 3 files changed

// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: op encodings, FSM state
// encoding and the carry helper used by the per-bit slice.
package serial_alu_pkg;

    // Operation select encodings (sel port)
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Carry of a full adder: majority of the three inputs
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice: computes the selected op on a single bit position.
// Only ADD produces a carry; logic ops force cout to 0 so the carry flop
// in the top stays clear for them and doubles as the cout output.
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] sel,
    output logic       y,
    output logic       cout
);

    // Per-bit op decode
    always_comb begin
        y    = 1'b0;
        cout = 1'b0;
        case (sel)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_ADD: begin
                y    = a ^ b ^ cin;
                cout = maj3(a, b, cin);
            end
            default: begin
                y    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: operands are captured on an accepted start, then one bit
// per clock is processed LSB first through a single slice. The result
// shifts in from the MSB so it lands aligned after WIDTH RUN cycles.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [1:0]       op;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             bit_y;
    logic             bit_c;
    logic             last_bit;

    serial_alu_slice u_slice (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sel  (op),
        .y    (bit_y),
        .cout (bit_c)
    );

    // Counter reaching WIDTH-1 means this edge processes the MSB
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Control FSM: IDLE accepts start, RUN walks the bits, DONE pulses once
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start)    state <= ST_RUN;
                ST_RUN:  if (last_bit) state <= ST_DONE;
                ST_DONE:               state <= ST_IDLE;
                default:               state <= ST_IDLE;
            endcase
        end
    end

    // Datapath: capture on accept, shift one bit per RUN cycle, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            op     <= OP_AND;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        op    <= sel;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {bit_y, res_sh[WIDTH-1:1]};
                    carry  <= bit_c;
                    cnt    <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);
    assign result = res_sh;
    // After the MSB the carry flop holds the final carry (0 for logic ops)
    assign cout   = carry;

endmodule
